cvita_cmd_arbiter: RTL

- Shares one NoC Shell control-source port pair (cmdout/ackin) between NUM_REQ requesters.
- Each requester issues CVITA command packets. The arbiter grants one requester at a time, round-robin, and forwards its packet to cmdout.
- It then holds the grant until the matching ack packet returns on ackin, and routes that ack back to the granted requester.
- Sits between user command generators and noc_shell cmdout_*/ackin_* in the ce_clk domain.

---
 rtl/cvita_cmd_arbiter_if.sv | 36 +++
 rtl/cvita_cmd_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cvita_cmd_arbiter_if.sv
// Handshake bundle for cvita_cmd_arbiter: per-requester command/ack streams plus
// the shared noc_shell cmdout/ackin pair. slave = arbiter side, master = environment side.
interface cvita_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [64*NUM_REQ-1:0] s_cmd_tdata;
    logic [NUM_REQ-1:0]    s_cmd_tlast;
    logic [NUM_REQ-1:0]    s_cmd_tvalid;
    logic [NUM_REQ-1:0]    s_cmd_tready;
    logic [63:0]           m_cmd_tdata;
    logic                  m_cmd_tlast;
    logic                  m_cmd_tvalid;
    logic                  m_cmd_tready;
    logic [63:0]           s_ack_tdata;
    logic                  s_ack_tlast;
    logic                  s_ack_tvalid;
    logic                  s_ack_tready;
    logic [64*NUM_REQ-1:0] m_ack_tdata;
    logic [NUM_REQ-1:0]    m_ack_tlast;
    logic [NUM_REQ-1:0]    m_ack_tvalid;
    logic [NUM_REQ-1:0]    m_ack_tready;

    modport slave (
        input  s_cmd_tdata, s_cmd_tlast, s_cmd_tvalid, m_cmd_tready,
        input  s_ack_tdata, s_ack_tlast, s_ack_tvalid, m_ack_tready,
        output s_cmd_tready, m_cmd_tdata, m_cmd_tlast, m_cmd_tvalid,
        output s_ack_tready, m_ack_tdata, m_ack_tlast, m_ack_tvalid
    );

    modport master (
        output s_cmd_tdata, s_cmd_tlast, s_cmd_tvalid, m_cmd_tready,
        output s_ack_tdata, s_ack_tlast, s_ack_tvalid, m_ack_tready,
        input  s_cmd_tready, m_cmd_tdata, m_cmd_tlast, m_cmd_tvalid,
        input  s_ack_tready, m_ack_tdata, m_ack_tlast, m_ack_tvalid
    );
endinterface

// File: rtl/cvita_cmd_arbiter.sv
// Round-robin arbiter sharing one CVITA cmdout/ackin pair among NUM_REQ requesters.
// Optional ack-wait timeout: define CVITA_CMD_ARBITER_ACK_TIMEOUT_EN.
module cvita_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    cvita_cmd_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]  grant,
    output logic                busy,
    output logic                seq_err_stb,
    output logic                stray_ack_stb,
    output logic                timeout_stb
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_ACK} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [11:0]        seq_q, seq_d;
    logic               cmd_first_q, cmd_first_d;
    logic               ack_first_q, ack_first_d;
    logic               seq_err_q, seq_err_d;
    logic               cmd_hs, ack_hs, ack_wait_expired;
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx, arb_try_idx;
    int                 arb_try;

    assign cmd_hs = (state_q == CMD) && bus.s_cmd_tvalid[gidx_q] && bus.m_cmd_tready;
    assign ack_hs = (state_q == WAIT_ACK) && bus.s_ack_tvalid && bus.m_ack_tready[gidx_q];

    // First valid requester after the last one granted, wrapping modulo NUM_REQ.
    always_comb begin
        arb_found   = 1'b0;
        arb_idx     = '0;
        arb_try     = 0;
        arb_try_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_try     = (int'(rr_ptr_q) + k) % NUM_REQ;
            arb_try_idx = IDX_W'(arb_try);
            if (!arb_found && bus.s_cmd_tvalid[arb_try_idx]) begin
                arb_found = 1'b1;
                arb_idx   = arb_try_idx;
            end
        end
    end

    always_comb begin
        bus.m_cmd_tdata  = bus.s_cmd_tdata[64*gidx_q +: 64];
        bus.m_cmd_tlast  = bus.s_cmd_tlast[gidx_q];
        bus.m_cmd_tvalid = (state_q == CMD) && bus.s_cmd_tvalid[gidx_q];
        bus.s_cmd_tready = '0;
        if (state_q == CMD) bus.s_cmd_tready[gidx_q] = bus.m_cmd_tready;

        bus.m_ack_tdata  = {NUM_REQ{bus.s_ack_tdata}};
        bus.m_ack_tlast  = {NUM_REQ{bus.s_ack_tlast}};
        bus.m_ack_tvalid = '0;
        // Outside WAIT_ACK ackin is drained so a stray ack cannot wedge noc_shell.
        bus.s_ack_tready = !reset;
        if (state_q == WAIT_ACK) begin
            bus.m_ack_tvalid[gidx_q] = bus.s_ack_tvalid;
            bus.s_ack_tready         = bus.m_ack_tready[gidx_q] && !reset;
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        seq_d       = seq_q;
        cmd_first_d = cmd_first_q;
        ack_first_d = ack_first_q;
        seq_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = CMD;
                    gidx_d      = arb_idx;
                    rr_ptr_d    = arb_idx;
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    cmd_first_d = 1'b1;
                end
            end
            CMD: begin
                if (cmd_hs) begin
                    cmd_first_d = 1'b0;
                    if (cmd_first_q) seq_d = bus.m_cmd_tdata[59:48];
                    if (bus.m_cmd_tlast) begin
                        state_d     = WAIT_ACK;
                        ack_first_d = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_hs) begin
                    ack_first_d = 1'b0;
                    if (ack_first_q) seq_err_d = (bus.s_ack_tdata[59:48] != seq_q);
                    if (bus.s_ack_tlast) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (ack_wait_expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            seq_q       <= '0;
            cmd_first_q <= 1'b0;
            ack_first_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            seq_q       <= seq_d;
            cmd_first_q <= cmd_first_d;
            ack_first_q <= ack_first_d;
            seq_err_q   <= seq_err_d;
        end
    end

`ifdef CVITA_CMD_ARBITER_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             ack_seen_q;
    logic             timeout_q;

    // Counter is zero in the first WAIT_ACK cycle; expiry fires on its last count.
    assign ack_wait_expired = !ack_seen_q && !ack_hs &&
                              (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            ack_seen_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= (state_q == WAIT_ACK) && ack_wait_expired;
            if (state_q != WAIT_ACK) begin
                wait_cnt_q <= '0;
                ack_seen_q <= 1'b0;
            end else begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
                if (ack_hs) ack_seen_q <= 1'b1;
            end
        end
    end

    assign timeout_stb = timeout_q;
`else
    assign ack_wait_expired = 1'b0;
    assign timeout_stb      = 1'b0;
`endif

    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign seq_err_stb   = seq_err_q;
    assign stray_ack_stb = !reset && (state_q != WAIT_ACK) && bus.s_ack_tvalid && bus.s_ack_tlast;
endmodule
